ft232h_bus_arbiter: RTL and testbench

FT232H_BUS_ARBITER -- requirements
Module: ft232h_bus_arbiter

---
 rtl/ft232h_pkg.sv | 51 +++++
 rtl/ft232h_bus_arbiter_if.sv | 40 ++++
 rtl/ft232h_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_ft232h_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft232h_pkg.sv
// ============================================================================
// Module      : ft232h_pkg
// Description : Shared FSM state, grant and direction encodings, default
//               parameters and the arbitration helper for ft232h_bus_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ft232h_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RX_OE    = 3'd1,
        S_RX_READ  = 3'd2,
        S_TX_WRITE = 3'd3,
        S_TURN     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_RX   = 2'b01,
        GRANT_TX   = 2'b10
    } grant_e;

    typedef enum logic {
        DIR_RX = 1'b0,
        DIR_TX = 1'b1
    } dir_e;

    localparam int unsigned c_BURST_MAX_DEFAULT   = 64;
    localparam int unsigned c_TURN_CYCLES_DEFAULT = 2;

    // Contention goes to the direction that did not own the bus last.
    function automatic state_e arb_pick(input logic rx_req,
                                        input logic tx_req,
                                        input dir_e last_dir);
        state_e pick;
        pick = S_IDLE;
        if (rx_req && tx_req) begin
            pick = (last_dir == DIR_RX) ? S_TX_WRITE : S_RX_OE;
        end else if (rx_req) begin
            pick = S_RX_OE;
        end else if (tx_req) begin
            pick = S_TX_WRITE;
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ft232h_bus_arbiter_if.sv
// ============================================================================
// Module      : ft232h_bus_arbiter_if
// Description : FT232H sync-FIFO bus, local RX/TX FIFO handshakes and grant.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ft232h_bus_arbiter_if;

    logic       rxf_n;
    logic       txe_n;
    logic       oe_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] ft_data_in;
    logic [7:0] ft_data_out;
    logic       ft_data_oe;
    logic       rx_fifo_full;
    logic       rx_wr_en;
    logic [7:0] rx_data;
    logic       tx_fifo_empty;
    logic       tx_rd_en;
    logic [7:0] tx_data;
    logic [1:0] grant;

    modport master (
        input  rxf_n, txe_n, ft_data_in, rx_fifo_full, tx_fifo_empty, tx_data,
        output oe_n, rd_n, wr_n, ft_data_out, ft_data_oe,
               rx_wr_en, rx_data, tx_rd_en, grant
    );

    modport slave (
        output rxf_n, txe_n, ft_data_in, rx_fifo_full, tx_fifo_empty, tx_data,
        input  oe_n, rd_n, wr_n, ft_data_out, ft_data_oe,
               rx_wr_en, rx_data, tx_rd_en, grant
    );

endinterface

`default_nettype wire

// File: rtl/ft232h_bus_arbiter.sv
// ============================================================================
// Module      : ft232h_bus_arbiter
// Description : Half-duplex FT232H bus owner alternating RX and TX bursts with
//               a bus turnaround gap. Define FT_BURST_LIMIT_EN to cap beats
//               per grant at BURST_MAX.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ft232h_bus_arbiter
    import ft232h_pkg::*;
#(
    parameter int unsigned BURST_MAX   = c_BURST_MAX_DEFAULT,
    parameter int unsigned TURN_CYCLES = c_TURN_CYCLES_DEFAULT
) (
    input  wire logic             clock,
    input  wire logic             rst_n,
    ft232h_bus_arbiter_if.master  bus
);

    localparam logic [3:0] c_TURN_LAST = 4'(TURN_CYCLES - 1);

    if ((BURST_MAX < 1) || (BURST_MAX > 255) ||
        (TURN_CYCLES < 1) || (TURN_CYCLES > 15)) begin : g_param_check
        $error("ft232h_bus_arbiter: BURST_MAX or TURN_CYCLES out of range");
    end

    state_e     state_q, state_d;
    logic [3:0] turn_cnt_q, turn_cnt_d;
    dir_e       last_dir_q, last_dir_d;

    logic   w_rx_req;
    logic   w_tx_req;
    logic   w_arb;
    logic   w_strobe;
    logic   w_beat_last;
    state_e w_pick;

    assign w_rx_req = !bus.rxf_n && !bus.rx_fifo_full;
    assign w_tx_req = !bus.txe_n && !bus.tx_fifo_empty;
    assign w_pick   = arb_pick(w_rx_req, w_tx_req, last_dir_q);
    assign w_arb    = (state_q == S_IDLE) ||
                      ((state_q == S_TURN) && (turn_cnt_q == c_TURN_LAST));
    assign w_strobe = ((state_q == S_RX_READ)  && w_rx_req) ||
                      ((state_q == S_TX_WRITE) && w_tx_req);

    // The FT232H presents the byte in the same cycle rd_n is low.
    assign bus.rx_data = bus.ft_data_in;

`ifdef FT_BURST_LIMIT_EN
    localparam logic [7:0] c_BEAT_LAST = 8'(BURST_MAX - 1);

    logic [7:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (w_arb) begin
            beat_cnt_d = '0;
        end else if (w_strobe) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign w_beat_last = w_strobe && (beat_cnt_q == c_BEAT_LAST);
`else
    assign w_beat_last = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            turn_cnt_q <= '0;
            last_dir_q <= DIR_TX;
        end else begin
            state_q    <= state_d;
            turn_cnt_q <= turn_cnt_d;
            last_dir_q <= last_dir_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        turn_cnt_d      = turn_cnt_q;
        last_dir_d      = last_dir_q;
        bus.oe_n        = 1'b1;
        bus.rd_n        = 1'b1;
        bus.wr_n        = 1'b1;
        bus.ft_data_oe  = 1'b0;
        bus.ft_data_out = 8'h00;
        bus.rx_wr_en    = 1'b0;
        bus.tx_rd_en    = 1'b0;
        bus.grant       = GRANT_NONE;

        case (state_q)
            S_RX_OE: begin
                bus.oe_n  = 1'b0;
                bus.grant = GRANT_RX;
                state_d   = S_RX_READ;
            end
            S_RX_READ: begin
                bus.oe_n  = 1'b0;
                bus.grant = GRANT_RX;
                if (w_rx_req) begin
                    bus.rd_n     = 1'b0;
                    bus.rx_wr_en = 1'b1;
                    if (w_beat_last) begin
                        state_d = S_TURN;
                    end
                end else begin
                    state_d = S_TURN;
                end
            end
            S_TX_WRITE: begin
                bus.ft_data_oe  = 1'b1;
                bus.ft_data_out = bus.tx_data;
                bus.grant       = GRANT_TX;
                if (w_tx_req) begin
                    bus.wr_n     = 1'b0;
                    bus.tx_rd_en = 1'b1;
                    if (w_beat_last) begin
                        state_d = S_TURN;
                    end
                end else begin
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                turn_cnt_d = turn_cnt_q + 4'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The final turnaround cycle arbitrates directly so the idle gap
        // between back-to-back grants is exactly TURN_CYCLES.
        if (w_arb) begin
            state_d    = w_pick;
            turn_cnt_d = '0;
            if (w_pick == S_RX_OE) begin
                last_dir_d = DIR_RX;
            end else if (w_pick == S_TX_WRITE) begin
                last_dir_d = DIR_TX;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ft232h_bus_arbiter.sv
// ============================================================================
// Module      : tb_ft232h_bus_arbiter
// Description : Scoreboard bench for ft232h_bus_arbiter with FT232H/FIFO models.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ft232h_bus_arbiter;

`ifdef FT_BURST_LIMIT_EN
    localparam int unsigned TB_BURST = 4;
`else
    localparam int unsigned TB_BURST = 64;
`endif

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    ft232h_bus_arbiter_if bus ();

    ft232h_bus_arbiter #(
        .BURST_MAX   (TB_BURST),
        .TURN_CYCLES (2)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // FT232H receive source and upstream TX FIFO models
    logic [7:0] rx_src [0:31];
    logic [7:0] tx_mem [0:31];
    int         rx_ptr    = 0;
    int         rx_end    = 0;
    int         tx_rd_ptr = 0;
    int         tx_wr_ptr = 0;
    logic       txe_r     = 1'b1;
    logic       full_r    = 1'b0;

    assign bus.rxf_n         = (rx_ptr == rx_end);
    assign bus.ft_data_in    = rx_src[rx_ptr];
    assign bus.txe_n         = txe_r;
    assign bus.rx_fifo_full  = full_r;
    assign bus.tx_fifo_empty = (tx_rd_ptr == tx_wr_ptr);
    assign bus.tx_data       = tx_mem[tx_rd_ptr];

    always @(posedge clock) begin
        if (!bus.rd_n)    rx_ptr    <= rx_ptr + 1;
        if (bus.tx_rd_en) tx_rd_ptr <= tx_rd_ptr + 1;
    end

    typedef struct {
        logic [1:0] g;
        int         gap;
    } gexp_t;

    gexp_t      gq  [$];
    logic [7:0] rxq [$];
    logic [7:0] txq [$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic       mon_en      = 1'b0;
    logic [1:0] prev_grant  = 2'b00;
    int         gap_cnt     = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit cond(input int kind, input int val);
        case (kind)
            0:       return bus.grant == 2'(val);
            1:       return rx_ptr == val;
            default: return tx_rd_ptr == val;
        endcase
    endfunction

    task automatic wait_until(input int kind, input int val, input string name);
        int n = 0;
        while (!cond(kind, val) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check({name, "_timeout"}, 8'd1, 8'd0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((rxq.size() != 0 || txq.size() != 0 || gq.size() != 0 ||
                bus.grant != 2'b00) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check({name, "_drain_timeout"}, 8'd1, 8'd0);
        repeat (6) tick();
    endtask

    function automatic gexp_t ge(input logic [1:0] g, input int gap);
        gexp_t e;
        e.g   = g;
        e.gap = gap;
        return e;
    endfunction

    // Monitor: pops expected beats/grants whenever the DUT presents them
    always @(negedge clock) begin
        if (mon_en) begin
            check("rd_wr_overlap", 8'(!bus.rd_n && !bus.wr_n), 8'd0);
            check("oe_drive_clash", 8'(bus.ft_data_oe && !bus.oe_n), 8'd0);
            if (bus.rx_wr_en) begin
                check("rx_rd_n", 8'(bus.rd_n), 8'd0);
                if (rxq.size() == 0) check("rx_unexpected", bus.rx_data, 8'hxx);
                else                 check("rx_data", bus.rx_data, rxq.pop_front());
            end
            if (bus.tx_rd_en) begin
                check("tx_wr_n", 8'(bus.wr_n), 8'd0);
                check("tx_oe", 8'(bus.ft_data_oe), 8'd1);
                if (txq.size() == 0) check("tx_unexpected", bus.ft_data_out, 8'hxx);
                else                 check("tx_data", bus.ft_data_out, txq.pop_front());
            end
            if (bus.grant != 2'b00 && prev_grant == 2'b00) begin
                if (gq.size() == 0) begin
                    check("grant_unexpected", 8'(bus.grant), 8'd0);
                end else begin
                    gexp_t e;
                    e = gq.pop_front();
                    check("grant", 8'(bus.grant), 8'(e.g));
                    if (e.gap >= 0) check("turn_gap", 8'(gap_cnt), 8'(e.gap));
                    if (e.g == 2'b01) check("rx_oe_cycle", {6'd0, bus.rd_n, bus.oe_n}, 8'b10);
                end
            end
            gap_cnt    = (bus.grant == 2'b00) ? gap_cnt + 1 : 0;
            prev_grant = bus.grant;
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_oe_n",  8'(bus.oe_n), 8'd1);
        check("rst_rd_n",  8'(bus.rd_n), 8'd1);
        check("rst_wr_n",  8'(bus.wr_n), 8'd1);
        check("rst_data_oe", 8'(bus.ft_data_oe), 8'd0);
        check("rst_rx_wr_en", 8'(bus.rx_wr_en), 8'd0);
        check("rst_tx_rd_en", 8'(bus.tx_rd_en), 8'd0);
        check("rst_grant", 8'(bus.grant), 8'd0);
        check("rst_data_out", bus.ft_data_out, 8'h00);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        tick();

        // RX burst of four bytes
        gq.push_back(ge(2'b01, -1));
        for (int i = 0; i < 4; i++) begin
            rx_src[i] = 8'h11 + 8'(i);
            rxq.push_back(8'h11 + 8'(i));
        end
        rx_end = 4;
        drain("rx_burst");

        // TX burst of three bytes
        txe_r = 1'b0;
        gq.push_back(ge(2'b10, -1));
        for (int i = 0; i < 3; i++) begin
            tx_mem[i] = 8'hA0 + 8'(i);
            txq.push_back(8'hA0 + 8'(i));
        end
        tx_wr_ptr = 3;
        drain("tx_burst");

        // Contention: RX, TX, RX, TX with turnaround gaps
        gq.push_back(ge(2'b01, -1));
        gq.push_back(ge(2'b10, 2));
        gq.push_back(ge(2'b01, 2));
        gq.push_back(ge(2'b10, 2));
        for (int i = 0; i < 4; i++) begin
            rx_src[4 + i] = 8'h21 + 8'(i);
            rxq.push_back(8'h21 + 8'(i));
        end
        for (int i = 0; i < 3; i++) begin
            tx_mem[3 + i] = 8'hB0 + 8'(i);
            txq.push_back(8'hB0 + 8'(i));
        end
        rx_end    = 6;
        tx_wr_ptr = 5;
        wait_until(0, 2, "contend_tx");
        rx_end = 8;
        wait_until(0, 1, "contend_rx2");
        tx_wr_ptr = 6;
        drain("contend");

        // RX FIFO fills on beat 3
        gq.push_back(ge(2'b01, -1));
        gq.push_back(ge(2'b01, -1));
        for (int i = 0; i < 5; i++) begin
            rx_src[8 + i] = 8'h31 + 8'(i);
            rxq.push_back(8'h31 + 8'(i));
        end
        rx_end = 13;
        wait_until(1, 10, "full_beat2");
        full_r = 1'b1;
        @(negedge clock);
        check("full_rd_n", 8'(bus.rd_n), 8'd1);
        check("full_grant", 8'(bus.grant), 8'd1);
        check("full_rx_ptr", 8'(rx_ptr), 8'd10);
        tick();
        repeat (5) tick();
        full_r = 1'b0;
        drain("rx_full");

        // Reset during TX beat 2, then RX must win contention
        gq.push_back(ge(2'b10, -1));
        txq.push_back(8'hC0);
        txq.push_back(8'hC1);
        for (int i = 0; i < 4; i++) tx_mem[6 + i] = 8'hC0 + 8'(i);
        tx_wr_ptr = 10;
        wait_until(2, 7, "tx_beat1");
        rst_n = 1'b0;
        tick();
        check("mid_rst_wr_n", 8'(bus.wr_n), 8'd1);
        check("mid_rst_data_oe", 8'(bus.ft_data_oe), 8'd0);
        check("mid_rst_grant", 8'(bus.grant), 8'd0);
        check("mid_rst_tx_ptr", 8'(tx_rd_ptr), 8'd8);
        gq.push_back(ge(2'b01, -1));
        gq.push_back(ge(2'b10, 2));
        rxq.push_back(8'h41);
        txq.push_back(8'hC2);
        txq.push_back(8'hC3);
        rx_src[13] = 8'h41;
        rx_end     = 14;
        rst_n      = 1'b1;
        drain("post_reset");

`ifdef FT_BURST_LIMIT_EN
        // Burst cap of four beats, then re-grant RX
        gq.push_back(ge(2'b01, -1));
        gq.push_back(ge(2'b01, 2));
        for (int i = 0; i < 6; i++) begin
            rx_src[14 + i] = 8'h51 + 8'(i);
            rxq.push_back(8'h51 + 8'(i));
        end
        rx_end = 20;
        drain("burst_limit");
`endif

        check("rxq_left", 8'(rxq.size()), 8'd0);
        check("txq_left", 8'(txq.size()), 8'd0);
        check("gq_left", 8'(gq.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
